wave_capture: RTL

WAVE_CAPTURE -- requirements
Module: wave_capture

---
 rtl/wave_capture.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/wave_capture.sv
// wave_capture
// ------------
// Triggered, double-buffered waveform capture for a scope-style renderer.
// Valid ADC samples are searched for a rising crossing of triggerLevel:
// the block arms on a sample below the level and triggers on a later sample
// at or above it. If no trigger arrives within AUTO_TIMEOUT valid samples,
// a capture is forced instead. A captured frame of CAPTURE_DEPTH samples
// fills the write bank. The banks swap only when the renderer signals the
// end of its visible frame while a completed capture is waiting.
//
// Parameters
//   DATA_IN_BITS  : sample width (unsigned)
//   ADDRESS_BITS  : read/write address width
//   CAPTURE_DEPTH : samples per frame, must not exceed 2**ADDRESS_BITS
//   AUTO_TIMEOUT  : valid samples to wait before auto-capture, 0 disables it
//
// Ports
//   clock         in   rising-edge clock for all logic and both banks
//   reset         in   asynchronous, active-high reset
//   dataIn        in   ADC sample, qualified by dataValid
//   dataValid     in   dataIn carries a new sample this cycle
//   triggerLevel  in   rising-edge trigger threshold (unsigned)
//   drawStarting  in   one-cycle pulse at the end of the visible frame
//   readAddress   in   renderer sample index
//   dataOut       out  read-bank sample at readAddress, one clock later
//   frameReady    out  a completed capture is waiting for a swap
//   triggerPulse  out  one-cycle pulse after a real trigger is accepted
//   autoTriggered out  frame in the read bank came from a timeout
module wave_capture #(
  parameter int DATA_IN_BITS  = 12,
  parameter int ADDRESS_BITS  = 11,
  parameter int CAPTURE_DEPTH = 1024,
  parameter int AUTO_TIMEOUT  = 200000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_IN_BITS-1:0] dataIn,
  input  logic                    dataValid,
  input  logic [DATA_IN_BITS-1:0] triggerLevel,
  input  logic                    drawStarting,
  input  logic [ADDRESS_BITS-1:0] readAddress,
  output logic [DATA_IN_BITS-1:0] dataOut,
  output logic                    frameReady,
  output logic                    triggerPulse,
  output logic                    autoTriggered
);

  // Both banks live in one array: bank b occupies words
  // [b*CAPTURE_DEPTH, (b+1)*CAPTURE_DEPTH).
  localparam int MEM_WORDS = 2 * CAPTURE_DEPTH;
  localparam int IDX_BITS  = $clog2(MEM_WORDS);
  localparam int TO_BITS   = (AUTO_TIMEOUT > 0) ? $clog2(AUTO_TIMEOUT + 1) : 1;

  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(CAPTURE_DEPTH - 1);
  localparam logic [TO_BITS-1:0]      TO_LIMIT  = TO_BITS'(AUTO_TIMEOUT);

  typedef enum logic [1:0] {
    ST_ARM,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_FULL
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] write_addr_q, write_addr_d;
  logic [TO_BITS-1:0]      timeout_q, timeout_d;
  logic                    pending_auto_q, pending_auto_d;
  logic                    auto_triggered_q, auto_triggered_d;
  logic                    trigger_pulse_q, trigger_pulse_d;
  logic                    read_bank_q, read_bank_d;
  logic [DATA_IN_BITS-1:0] data_out_q;

  logic [DATA_IN_BITS-1:0] mem [0:MEM_WORDS-1];

  // Decoded events for the current cycle
  logic                    sample_below;
  logic                    in_hunt;
  logic [TO_BITS-1:0]      timeout_inc;
  logic                    trig_hit;
  logic                    auto_hit;
  logic                    capture_done;
  logic                    swap;

  // Output-decode signals
  logic                    frame_ready;
  logic                    wr_en;
  logic [ADDRESS_BITS-1:0] wr_addr;
  logic [IDX_BITS-1:0]     wr_idx;
  logic [IDX_BITS-1:0]     rd_idx;
  logic                    rd_in_range;

  function automatic logic [IDX_BITS-1:0] bank_index(
    input logic                    bank,
    input logic [ADDRESS_BITS-1:0] addr
  );
    int base;
    base = bank ? CAPTURE_DEPTH : 0;
    return IDX_BITS'(base + int'(addr));
  endfunction

  assign sample_below = dataIn < triggerLevel;
  assign in_hunt      = (state_q == ST_ARM) || (state_q == ST_WAIT_TRIG);
  assign timeout_inc  = timeout_q + TO_BITS'(1);
  assign trig_hit     = (state_q == ST_WAIT_TRIG) && dataValid && !sample_below;
  // A trigger on the same sample as the timeout takes priority.
  assign auto_hit     = (AUTO_TIMEOUT != 0) && in_hunt && dataValid &&
                        (timeout_inc == TO_LIMIT) && !trig_hit;
  assign capture_done = (state_q == ST_CAPTURE) && dataValid && (write_addr_q == LAST_ADDR);
  assign swap         = (state_q == ST_FULL) && drawStarting;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_ARM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM: begin
        if (auto_hit) begin
          state_d = ST_CAPTURE;
        end else if (dataValid && sample_below) begin
          state_d = ST_WAIT_TRIG;
        end
      end
      ST_WAIT_TRIG: begin
        if (trig_hit || auto_hit) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (capture_done) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (drawStarting) begin
          state_d = ST_ARM;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_comb begin
    frame_ready = (state_q == ST_FULL);
    // The accepted trigger/timeout sample is the first word of the frame.
    wr_en       = dataValid && ((state_q == ST_CAPTURE) || trig_hit || auto_hit);
    wr_addr     = (state_q == ST_CAPTURE) ? write_addr_q : '0;
  end

  // ---------------------------------------------------------- datapath
  always_comb begin
    write_addr_d     = write_addr_q;
    timeout_d        = timeout_q;
    pending_auto_d   = pending_auto_q;
    auto_triggered_d = auto_triggered_q;
    trigger_pulse_d  = trig_hit;
    read_bank_d      = read_bank_q;

    if (trig_hit || auto_hit) begin
      write_addr_d = ADDRESS_BITS'(1);
    end else if ((state_q == ST_CAPTURE) && dataValid && !capture_done) begin
      write_addr_d = write_addr_q + ADDRESS_BITS'(1);
    end

    // The only non-reset entry into ARM is the swap out of FULL.
    if (swap) begin
      timeout_d = '0;
    end else if (in_hunt && dataValid && (AUTO_TIMEOUT != 0)) begin
      timeout_d = timeout_inc;
    end

    if (auto_hit) begin
      pending_auto_d = 1'b1;
    end else if (trig_hit) begin
      pending_auto_d = 1'b0;
    end

    if (swap) begin
      auto_triggered_d = pending_auto_q;
      read_bank_d      = ~read_bank_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_addr_q     <= '0;
      timeout_q        <= '0;
      pending_auto_q   <= 1'b0;
      auto_triggered_q <= 1'b0;
      trigger_pulse_q  <= 1'b0;
      read_bank_q      <= 1'b0;
    end else begin
      write_addr_q     <= write_addr_d;
      timeout_q        <= timeout_d;
      pending_auto_q   <= pending_auto_d;
      auto_triggered_q <= auto_triggered_d;
      trigger_pulse_q  <= trigger_pulse_d;
      read_bank_q      <= read_bank_d;
    end
  end

  // ------------------------------------------------------ sample banks
  // The write bank is always the complement of the read bank.
  assign wr_idx      = bank_index(~read_bank_q, wr_addr);
  assign rd_idx      = bank_index(read_bank_q, readAddress);
  assign rd_in_range = int'(readAddress) < CAPTURE_DEPTH;

  // Bank contents survive reset, so the array has no reset term.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= dataIn;
    end
  end

  // Reads use the bank selector as it stands before any swap on this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
    end else if (rd_in_range) begin
      data_out_q <= mem[rd_idx];
    end else begin
      data_out_q <= '0;
    end
  end

  assign dataOut       = data_out_q;
  assign frameReady    = frame_ready;
  assign triggerPulse  = trigger_pulse_q;
  assign autoTriggered = auto_triggered_q;

endmodule
